// File: rtl/rx_pkg.sv
// Shared constants and types for the UART receive FIFO.
// Entry layout is {err, data}; occupancy is derived from the count.
package rx_pkg;

    localparam int RX_FIFO_DEPTH_DEF = 16;
    localparam int RX_DATA_W         = 8;
    localparam int RX_PTR_W          = $clog2(RX_FIFO_DEPTH_DEF);

    typedef struct packed {
        logic                 err;
        logic [RX_DATA_W-1:0] data;
    } rx_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_t;

endpackage

// File: rtl/rx_fifo_if.sv
// Receiver-side capture signals plus host-side FWFT read port.
// master = receiver/host side, slave = the FIFO.
interface rx_fifo_if
    import rx_pkg::*;
#(
    parameter int DEPTH = RX_FIFO_DEPTH_DEF,
    parameter int WIDTH = RX_DATA_W
);

    logic                     DoneFlag;
    logic                     ErrorFlag;
    logic [WIDTH-1:0]         Data;
    logic                     ReadEn;
    logic                     ClearOverrun;
    logic [WIDTH-1:0]         RdData;
    logic                     RdError;
    logic                     Empty;
    logic                     Full;
    logic [$clog2(DEPTH):0]   Count;
    logic                     Overrun;
    logic [7:0]               DropCount;

    modport master (
        output DoneFlag, ErrorFlag, Data, ReadEn, ClearOverrun,
        input  RdData, RdError, Empty, Full, Count, Overrun, DropCount
    );

    modport slave (
        input  DoneFlag, ErrorFlag, Data, ReadEn, ClearOverrun,
        output RdData, RdError, Empty, Full, Count, Overrun, DropCount
    );

endinterface

// File: rtl/rx_sync_edge.sv
// Two-flop synchroniser with a single-cycle rising-edge pulse output.
// A level already high when reset releases is not reported as an edge.
module rx_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic pulse_o
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;
    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic arm_q, arm_d;

    // v1/v2 track when s2 holds a real sample; arm only after seeing it low
    always_comb begin
        s1_d  = async_i;
        s2_d  = s1_q;
        s3_d  = s2_q;
        v1_d  = 1'b1;
        v2_d  = v1_q;
        arm_d = arm_q | (v2_q & ~s2_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            s3_q  <= 1'b0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            arm_q <= 1'b0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            s3_q  <= s3_d;
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            arm_q <= arm_d;
        end
    end

    assign pulse_o = s2_q & ~s3_q & arm_q;

endmodule

// File: rtl/rx_fifo.sv
// FWFT receive buffer behind the UART receiver; never stalls the receiver.
// Define RX_FIFO_ERR_DROP_EN to discard errored frames and count them.
module rx_fifo
    import rx_pkg::*;
#(
    parameter int DEPTH = RX_FIFO_DEPTH_DEF,
    parameter int WIDTH = RX_DATA_W
) (
    input  logic     Clock,
    input  logic     ResetN,
    rx_fifo_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic          push;
    rx_entry_t     wr_ent;
    rx_entry_t     mem_q [DEPTH];
    rx_entry_t     mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    occ_t          occ;
    logic          empty, full;
    logic          err_drop, keep;
    logic          do_wr, do_rd, ovf;

    rx_sync_edge u_sync (
        .clk     (Clock),
        .rst_n   (ResetN),
        .async_i (bus.DoneFlag),
        .pulse_o (push)
    );

    always_comb begin
        wr_ent.err  = bus.ErrorFlag;
        wr_ent.data = bus.Data;
    end

    always_comb begin
        occ = OCC_PARTIAL;
        if (count_q == '0)
            occ = OCC_EMPTY;
        else if (count_q == CW'(DEPTH))
            occ = OCC_FULL;
    end

    assign empty = (occ == OCC_EMPTY);
    assign full  = (occ == OCC_FULL);

`ifdef RX_FIFO_ERR_DROP_EN
    assign err_drop = push & bus.ErrorFlag;
`else
    assign err_drop = 1'b0;
`endif

    // a pop from a full FIFO frees the slot the same-cycle push lands in
    assign keep  = push & ~err_drop;
    assign do_rd = bus.ReadEn & ~empty;
    assign do_wr = keep & (~full | do_rd);
    assign ovf   = keep & full & ~do_rd;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_ent;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_rd)
            rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_comb begin
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        overrun_d  = (overrun_q & ~bus.ClearOverrun) | ovf;
        drop_cnt_d = drop_cnt_q;
        if (err_drop && drop_cnt_q != 8'hFF)
            drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.RdData    = mem_q[rd_ptr_q].data;
`ifdef RX_FIFO_ERR_DROP_EN
    assign bus.RdError   = 1'b0;
`else
    assign bus.RdError   = mem_q[rd_ptr_q].err;
`endif
    assign bus.Empty     = empty;
    assign bus.Full      = full;
    assign bus.Count     = count_q;
    assign bus.Overrun   = overrun_q;
    assign bus.DropCount = drop_cnt_q;

endmodule
